// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- handshaked execute-stage ALU
//
// Accepts one operation per in_valid/in_ready transfer. Logic, add/sub, move,
// shift and compare ops complete in one cycle; mul runs an iterative
// shift-add multiplier (one multiplier bit per cycle, WIDTH cycles). The
// result is held in DONE until downstream takes it with out_ready. A DONE
// result handed off in the same cycle as a new single-cycle accept gives
// one result per cycle.
//
// Configuration macro:
//   ALU_SIGNED_CMP_EN  defined   -> cmp greater/less is two's-complement signed
//                      undefined -> cmp greater/less is unsigned
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake
//   alusignals[12:0]    one-hot op select (add,ld,st,sub,mul,cmp,mov,or,and,
//                       not,lsl,lsr,xor); lowest set bit wins, none -> 0
//   op1, op2, immx      operands; isimmediate picks zero-extended immx as B
//   out_valid/out_ready result handshake; aluresult stable while stalled
//   cmp_flag[1:0]       last compare: 1 equal, 2 greater, 0 less
//   busy                multiplier running
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 5,
  parameter int SHAMT_W   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [12:0]          alusignals,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [IMM_WIDTH-1:0] immx,
  input  logic                 isimmediate,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     aluresult,
  output logic [1:0]           cmp_flag,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [12:0] SEL_ADD = 13'h0001;
  localparam logic [12:0] SEL_LD  = 13'h0002;
  localparam logic [12:0] SEL_ST  = 13'h0004;
  localparam logic [12:0] SEL_SUB = 13'h0008;
  localparam logic [12:0] SEL_MUL = 13'h0010;
  localparam logic [12:0] SEL_CMP = 13'h0020;
  localparam logic [12:0] SEL_MOV = 13'h0040;
  localparam logic [12:0] SEL_OR  = 13'h0080;
  localparam logic [12:0] SEL_AND = 13'h0100;
  localparam logic [12:0] SEL_NOT = 13'h0200;
  localparam logic [12:0] SEL_LSL = 13'h0400;
  localparam logic [12:0] SEL_LSR = 13'h0800;
  localparam logic [12:0] SEL_XOR = 13'h1000;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   WIDTH_V  = WIDTH'(WIDTH);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic [SHAMT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [1:0]         cmp_flag_reg, cmp_flag_next;

  logic [12:0]        op_onehot;
  logic [WIDTH-1:0]   a_val, b_val;
  logic [WIDTH-1:0]   single_result;
  logic [WIDTH-1:0]   acc_sum;
  logic               a_eq_b, a_gt_b, shift_oob, accept;

  // Priority reduce: a bit survives only if no lower-index bit is set.
  assign op_onehot[0] = alusignals[0];
  for (genvar gi = 1; gi < 13; gi++) begin : g_pri
    assign op_onehot[gi] = alusignals[gi] & ~(|alusignals[gi-1:0]);
  end

  assign a_val     = op1;
  assign b_val     = isimmediate ? WIDTH'(immx) : op2;
  assign a_eq_b    = (a_val == b_val);
  assign shift_oob = (b_val >= WIDTH_V);

`ifdef ALU_SIGNED_CMP_EN
  assign a_gt_b = $signed(a_val) > $signed(b_val);
`else
  assign a_gt_b = a_val > b_val;
`endif

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == MUL);
  assign aluresult = result_reg;
  assign cmp_flag  = cmp_flag_reg;

  // One partial product per cycle: multiplicand shifts left, multiplier right.
  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    single_result = '0;
    case (op_onehot)
      SEL_ADD, SEL_LD, SEL_ST: single_result = a_val + b_val;
      SEL_SUB: single_result = a_val - b_val;
      SEL_CMP: single_result = {{(WIDTH-1){1'b0}}, a_eq_b};
      SEL_MOV: single_result = b_val;
      SEL_OR:  single_result = a_val | b_val;
      SEL_AND: single_result = a_val & b_val;
      SEL_NOT: single_result = ~a_val;
      SEL_LSL: single_result = shift_oob ? '0 : (a_val << b_val[SHAMT_W-1:0]);
      SEL_LSR: single_result = shift_oob ? '0 : (a_val >> b_val[SHAMT_W-1:0]);
      SEL_XOR: single_result = a_val ^ b_val;
      default: single_result = '0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    mcand_next    = mcand_reg;
    mplier_next   = mplier_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    cmp_flag_next = cmp_flag_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          if (op_onehot == SEL_MUL) begin
            state_next  = MUL;
            mcand_next  = a_val;
            mplier_next = b_val;
            acc_next    = '0;
            cnt_next    = '0;
          end else begin
            state_next  = DONE;
            result_next = single_result;
            if (op_onehot == SEL_CMP) begin
              cmp_flag_next = a_eq_b ? 2'd1 : (a_gt_b ? 2'd2 : 2'd0);
            end
          end
        end else if ((state_reg == DONE) && out_ready) begin
          state_next = IDLE;
        end
      end
      MUL: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next  = DONE;
          result_next = acc_sum;
          cnt_next    = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      cmp_flag_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      mcand_reg    <= mcand_next;
      mplier_reg   <= mplier_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      cmp_flag_reg <= cmp_flag_next;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- scoreboard bench for alu_pipe
//
// The driver pushes the expected result/flag for every accepted operation;
// an independent monitor pops and compares on each output transfer.
// Directed checks cover latency, multiplier occupancy, backpressure,
// streaming throughput and reset during a multiply.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int IW = 5;

  localparam logic [12:0] K_ADD = 13'h0001;
  localparam logic [12:0] K_SUB = 13'h0008;
  localparam logic [12:0] K_MUL = 13'h0010;
  localparam logic [12:0] K_CMP = 13'h0020;
  localparam logic [12:0] K_LSL = 13'h0400;
  localparam logic [12:0] K_LSR = 13'h0800;
  localparam logic [12:0] K_XOR = 13'h1000;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, isimmediate;
  logic          out_valid, out_ready, busy;
  logic [12:0]   alusignals;
  logic [W-1:0]  op1, op2, aluresult;
  logic [IW-1:0] immx;
  logic [1:0]    cmp_flag;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alusignals(alusignals), .op1(op1), .op2(op2), .immx(immx),
    .isimmediate(isimmediate), .out_valid(out_valid), .out_ready(out_ready),
    .aluresult(aluresult), .cmp_flag(cmp_flag), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [1:0]   flag;
  } exp_t;

  exp_t     exp_q[$];
  exp_t     mon_e;
  int       tests_run    = 0;
  int       tests_failed = 0;
  int       cyc          = 0;
  logic [1:0] model_flag = 2'd0;
  bit       bp_random    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Behavioural reference: plain integer arithmetic on the op rules.
  function automatic exp_t model(input logic [12:0] sel, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [1:0] flag_in);
    exp_t   e;
    int     idx;
    longint ua, ub, sa, sb, md, r;
    idx = -1;
    for (int i = 12; i >= 0; i--) if (sel[i]) idx = i;
    md = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
`ifdef ALU_SIGNED_CMP_EN
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
`else
    sa = ua;
    sb = ub;
`endif
    e.flag = flag_in;
    r = 0;
    case (idx)
      0, 1, 2: r = (ua + ub) % md;
      3:       r = (ua - ub + md) % md;
      4:       r = (ua * ub) % md;
      5: begin
        r = (ua == ub) ? 1 : 0;
        e.flag = (ua == ub) ? 2'd1 : ((sa > sb) ? 2'd2 : 2'd0);
      end
      6:  r = ub;
      7:  r = ua | ub;
      8:  r = ua & ub;
      9:  r = (md - 1) - ua;
      10: r = (ub >= W) ? 0 : (ua * (longint'(1) << ub)) % md;
      11: r = (ub >= W) ? 0 : ua / (longint'(1) << ub);
      12: r = ua ^ ub;
      default: r = 0;
    endcase
    e.res = W'(r);
    return e;
  endfunction

  // Present one operation and hold it until accepted; returns on the
  // falling edge right after the accepting rising edge.
  task automatic issue(input logic [12:0] sel, input logic [W-1:0] a,
                       input logic [W-1:0] b_in, input logic [IW-1:0] imm,
                       input bit isimm, output int accept_cyc);
    logic [W-1:0] b_eff;
    exp_t e;
    int   guard;
    b_eff = isimm ? W'(imm) : b_in;
    alusignals  = sel;
    op1         = a;
    op2         = b_in;
    immx        = imm;
    isimmediate = isimm;
    in_valid    = 1'b1;
    guard       = 0;
    accept_cyc  = -1;
    forever begin
      if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) break;
      guard++;
      if (guard > 100) break;
      @(negedge clk);
    end
    if (guard > 100) begin
      tests_run++;
      tests_failed++;
      $display("FAIL handshake_timeout: in_ready never rose, expected 1 (cycle %0d)", cyc);
      in_valid = 1'b0;
    end else begin
      e = model(sel, a, b_eff, model_flag);
      model_flag = e.flag;
      exp_q.push_back(e);
      accept_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: an output transfer happens at the next rising edge when both
  // out_valid and out_ready are high mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_output: got %0h, expected no output (cycle %0d)", aluresult, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", int'(aluresult), int'(mon_e.res));
          check("cmp_flag", int'(cmp_flag), int'(mon_e.flag));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_c, first_c, last_c, n, bad;
    logic [12:0]   r_sel;
    logic [W-1:0]  r_a, r_b;
    logic [IW-1:0] r_imm;
    bit            r_isimm;
    int            k;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alusignals = '0;
    op1 = '0; op2 = '0; immx = '0; isimmediate = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_aluresult", int'(aluresult), 0);
    check("reset_cmp_flag", int'(cmp_flag), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);

    // add: out_valid the cycle after accept
    issue(K_ADD, 16'h0003, 16'h0004, '0, 1'b0, acc_c);
    check("add_latency_out_valid", int'(out_valid), 1);
    check("add_result_direct", int'(aluresult), 16'h0007);
    drain();

    issue(K_SUB, 16'h0001, 16'h0000, 5'h02, 1'b1, acc_c);
    drain();

    // mul occupancy: WIDTH cycles busy with in_ready low, then DONE
    issue(K_MUL, 16'h0123, 16'h0010, '0, 1'b0, acc_c);
    n = 0; bad = 0;
    while (!out_valid && n < 40) begin
      if (!busy || in_ready) bad++;
      n++;
      @(negedge clk);
    end
    check("mul_busy_cycles", n, W);
    check("mul_busy_in_ready_bad", bad, 0);
    check("mul_result_direct", int'(aluresult), 16'h1230);
    drain();
    issue(K_MUL, 16'h0100, 16'h0100, '0, 1'b0, acc_c);
    drain();

    issue(K_CMP, 16'd5, 16'd5, '0, 1'b0, acc_c);
    issue(K_CMP, 16'd9, 16'd5, '0, 1'b0, acc_c);
    issue(K_CMP, 16'hFFFF, 16'd1, '0, 1'b0, acc_c);
    drain();
`ifdef ALU_SIGNED_CMP_EN
    check("cmp_signed_flag", int'(cmp_flag), 0);
`else
    check("cmp_unsigned_flag", int'(cmp_flag), 2);
`endif

    // backpressure hold
    out_ready = 1'b0;
    issue(K_XOR, 16'hF0F0, 16'h0FF0, '0, 1'b0, acc_c);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (aluresult != 16'hFF00 || !out_valid || in_ready) bad++;
      @(negedge clk);
    end
    check("backpressure_hold_bad", bad, 0);

    // streaming: 4 adds, one accept per cycle
    out_ready = 1'b1;
    issue(K_ADD, 16'h1000, 16'h0001, '0, 1'b0, first_c);
    issue(K_ADD, 16'h2000, 16'h0002, '0, 1'b0, last_c);
    issue(K_ADD, 16'hFFFF, 16'h0003, '0, 1'b0, last_c);
    issue(K_ADD, 16'h4000, 16'h0004, '0, 1'b0, last_c);
    check("stream_accept_span", last_c - first_c, 3);
    drain();

    // boundaries
    issue(K_LSL, 16'h0001, 16'd16, '0, 1'b0, acc_c);
    issue(K_LSL, 16'h0001, 16'h0000, 5'h10, 1'b1, acc_c);
    issue(K_LSR, 16'h8000, 16'd15, '0, 1'b0, acc_c);
    issue(K_LSL, 16'h00F1, 16'h0104, '0, 1'b0, acc_c);
    issue(13'h0000, 16'h1234, 16'h5678, '0, 1'b0, acc_c);
    issue(13'h1008, 16'h0010, 16'h0001, '0, 1'b0, acc_c);
    drain();

    // reset during multiply discards the result
    issue(K_CMP, 16'd9, 16'd5, '0, 1'b0, acc_c);
    drain();
    issue(K_MUL, 16'h0033, 16'h0021, '0, 1'b0, acc_c);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_flag = 2'd0;
    check("mul_abort_in_ready", int'(in_ready), 1);
    check("mul_abort_cmp_flag", int'(cmp_flag), 0);
    check("mul_abort_busy", int'(busy), 0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) bad++;
      @(negedge clk);
    end
    check("mul_abort_no_out_valid", bad, 0);

    // randomized traffic with random backpressure
    bp_random = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 15));
      if (k < 13)       r_sel = 13'h0001 << k;
      else if (k == 13) r_sel = 13'($urandom);
      else if (k == 14) r_sel = '0;
      else              r_sel = ($urandom_range(0, 1) != 0) ? K_LSL : K_LSR;
      r_a     = W'($urandom);
      r_b     = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      r_imm   = IW'($urandom);
      r_isimm = ($urandom_range(0, 3) == 0);
      issue(r_sel, r_a, r_b, r_imm, r_isimm, acc_c);
    end
    bp_random = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the execute-stage ALU.
- Accepts one operation per valid/ready transfer and computes it over one or more cycles:
  - single-cycle logic, add/sub and shift ops;
  - an iterative shift-add multiplier for mul.
- Holds the result until downstream accepts it.
- Keeps the compare outcome in an internal flags register exposed as a port, so no file-based register side effects are needed.
- Sits between decode/operand-fetch and memory/writeback in each execute lane.

Parameters:
- WIDTH, 16, data width of op1/op2/aluresult.
- IMM_WIDTH, 5, width of immx; zero-extended to WIDTH.
- SHAMT_W, $clog2(WIDTH), number of low B bits examined for the shift amount.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- alusignals  in  13  one-hot op select; bit0..12 = add, ld, st, sub, mul, cmp, mov, or, and, not, lsl, lsr, xor.
- op1  in  WIDTH  operand A.
- op2  in  WIDTH  operand B when isimmediate=0.
- immx  in  IMM_WIDTH  immediate operand B.
- isimmediate  in  1  select zero-extended immx as B.
- out_valid  out  1  aluresult valid.
- out_ready  in  1  downstream accepts result.
- aluresult  out  WIDTH  result, held stable while out_valid && !out_ready.
- cmp_flag  out  2  last compare outcome: 2'd1 equal, 2'd2 greater, 2'd0 less.
- busy  out  1  high in MUL state.

Behaviour:
- Reset: rst is synchronous and active-high, sampled on the clk rising edge. Reset forces:
  - state=IDLE; out_valid=0; aluresult=0; cmp_flag=2'd0; busy=0;
  - multiplier counter=0.
  - Reset during MUL or DONE aborts the operation; the result is discarded and never presented.
- FSM states: IDLE, MUL, DONE.
- Ready and accept:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready. On accept, latch A=op1, B=(isimmediate ? zero-extend(immx) : op2) and the op.
- Op priority: if several alusignals bits are set, the lowest index wins (add highest). All-zero selects result 0.
- Single-cycle ops: on accept, the result registers at the same edge. Next state DONE, so out_valid=1 one cycle after accept.
  - add/ld/st: A+B mod 2^WIDTH.
  - sub: A-B mod 2^WIDTH.
  - mov: B.
  - or, and, xor: bitwise.
  - not: ~A.
  - lsl/lsr: logical shift by B[SHAMT_W-1:0]; if B >= WIDTH (any higher bit set), result 0.
  - cmp: result 1 if A==B else 0. cmp_flag updates on the same edge the result registers.
- mul: on accept, go to MUL. busy=1.
  - Each cycle, process one multiplier bit (LSB first); accumulate the partial product into the low WIDTH bits.
  - After exactly WIDTH cycles in MUL, go to DONE with the low WIDTH bits of A*B.
  - out_valid rises WIDTH+1 cycles after the accept edge.
  - in_ready=0 throughout MUL.
- DONE:
  - out_valid=1; aluresult and cmp_flag are stable.
  - If out_ready=0: stay in DONE.
  - If out_ready=1 and no new accept: go to IDLE, out_valid=0 next cycle.
  - If out_ready=1 with a simultaneous accept: back-to-back single-cycle ops stay in DONE with the new result next cycle (1 op/cycle throughput); a mul goes to MUL.
- cmp_flag changes only when a cmp op completes; other ops leave it unchanged.

Optional Feature:
- Macro ALU_SIGNED_CMP_EN.
  - Defined: cmp and its greater/less classification treat A and B as two's-complement signed WIDTH-bit values.
  - Undefined: unsigned comparison.
  - Equality behaviour is identical in both builds.

Test Plan:
- Reset then add: op1=16'h0003, op2=16'h0004, add, handshake -> out_valid one cycle after accept, aluresult=16'h0007, cmp_flag=0.
- Immediate sub wrap: op1=16'h0001, immx=5'h02, isimmediate=1, sub -> aluresult=16'hFFFF.
- mul: op1=16'h0123, op2=16'h0010 -> in_ready=0 and busy=1 for 16 cycles; aluresult=16'h1230 at cycle 17 after accept. Also op1=op2=16'h0100 -> 16'h0000 (truncated).
- cmp sequence: (5,5) -> result 1, cmp_flag=1; (9,5) -> result 0, cmp_flag=2; (16'hFFFF,1) -> cmp_flag=2 unsigned, 0 with ALU_SIGNED_CMP_EN.
- Backpressure and streaming:
  - Hold out_ready=0 for 5 cycles after xor(16'hF0F0,16'h0FF0) -> aluresult stays 16'hFF00, in_ready=0.
  - Then stream 4 adds with in_valid=out_ready=1 -> one result per cycle.
- Boundaries:
  - lsl by 16 -> 0; lsr 16'h8000 by 15 -> 16'h0001; all-zero alusignals -> 0.
  - rst asserted mid-mul -> out_valid never rises, cmp_flag=0, in_ready=1 next cycle.
